// File: rtl/vfpu_add_arbiter.sv
// Shares one combinational vfpu_add datapath among NB_REQ valid/ready requesters, one operation in flight.
// Define VFPU_ADD_ARB_RR_EN for round-robin grant starting at ptr_q; default build is fixed priority.
module vfpu_add_arbiter #(
    parameter int NB_REQ                = 4,
    parameter int ID_W                  = $clog2(NB_REQ),
    parameter int FP_EXP_WIDTH          = 8,
    parameter int FP_MANT_WIDTH         = 23,
    parameter int FP_EXP_PRENORM_WIDTH  = 10,
    parameter int FP_MANT_PRENORM_WIDTH = 28
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NB_REQ-1:0]                       req_valid_i,
    output logic [NB_REQ-1:0]                       req_ready_o,
    input  logic [NB_REQ-1:0][31:0]                 req_opa_i,
    input  logic [NB_REQ-1:0][31:0]                 req_opb_i,
    output logic                                    add_signA_o,
    output logic                                    add_signB_o,
    output logic [FP_EXP_WIDTH-1:0]                 add_exponentA_o,
    output logic [FP_EXP_WIDTH-1:0]                 add_exponentB_o,
    output logic [FP_MANT_WIDTH:0]                  add_mantissaA_o,
    output logic [FP_MANT_WIDTH:0]                  add_mantissaB_o,
    output logic                                    add_operandsReady_o,
    input  logic                                    add_done_i,
    input  logic                                    add_sign_i,
    input  logic signed [FP_EXP_PRENORM_WIDTH-1:0]  add_exponent_i,
    input  logic [FP_MANT_PRENORM_WIDTH-1:0]        add_mantissa_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic                                    res_sign_o,
    output logic signed [FP_EXP_PRENORM_WIDTH-1:0]  res_exponent_o,
    output logic [FP_MANT_PRENORM_WIDTH-1:0]        res_mantissa_o,
    output logic [ID_W-1:0]                         res_id_o
);

    // Handshakes: a request moves when req_valid_i[i] && req_ready_o[i]; a result moves when
    // res_valid_o && res_ready_i. Requesters hold valid and operands stable until accepted.
    typedef enum logic [1:0] {IDLE, OPER, RESP} state_e;

    typedef struct packed {
        logic                     sign;
        logic [FP_EXP_WIDTH-1:0]  exp;
        logic [FP_MANT_WIDTH:0]   mant;
    } fp_op_t;

    typedef struct packed {
        logic                              sign;
        logic [FP_EXP_PRENORM_WIDTH-1:0]   exp;
        logic [FP_MANT_PRENORM_WIDTH-1:0]  mant;
    } fp_res_t;

    // Denormals get a zero implied bit; NaN/Inf pass through untouched.
    function automatic fp_op_t unpack(input logic [31:0] x);
        fp_op_t u;
        u.sign = x[31];
        u.exp  = x[FP_EXP_WIDTH+FP_MANT_WIDTH-1:FP_MANT_WIDTH];
        u.mant = {|u.exp, x[FP_MANT_WIDTH-1:0]};
        return u;
    endfunction

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    fp_op_t          opa_q, opa_d, opb_q, opb_d;
    fp_res_t         res_q, res_d;

    logic            gnt_valid;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] idx;

    // Scan downward so the last hit, i.e. the first in search order, wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
`ifdef VFPU_ADD_ARB_RR_EN
            idx = ID_W'((int'(ptr_q) + k) % NB_REQ);
`else
            idx = ID_W'(k);
`endif
            if (req_valid_i[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        id_d                = id_q;
        opa_d               = opa_q;
        opb_d               = opb_q;
        res_d               = res_q;
        req_ready_o         = '0;
        add_operandsReady_o = 1'b0;
        res_valid_o         = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    opa_d   = unpack(req_opa_i[gnt_idx]);
                    opb_d   = unpack(req_opb_i[gnt_idx]);
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = OPER;
                end
            end
            OPER: begin
                add_operandsReady_o = 1'b1;
                if (add_done_i) begin
                    res_d.sign = add_sign_i;
                    res_d.exp  = add_exponent_i;
                    res_d.mant = add_mantissa_i;
                    state_d    = RESP;
                end
            end
            RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign add_signA_o     = opa_q.sign;
    assign add_signB_o     = opb_q.sign;
    assign add_exponentA_o = opa_q.exp;
    assign add_exponentB_o = opb_q.exp;
    assign add_mantissaA_o = opa_q.mant;
    assign add_mantissaB_o = opb_q.mant;
    assign res_sign_o      = res_q.sign;
    assign res_exponent_o  = res_q.exp;
    assign res_mantissa_o  = res_q.mant;
    assign res_id_o        = id_q;

endmodule

// File: tb/tb_vfpu_add_arbiter.sv
// Self-checking bench for vfpu_add_arbiter: transaction-level model compared every cycle,
// plus directed cases with hand-computed values. Honours VFPU_ADD_ARB_RR_EN like the DUT.
module tb_vfpu_add_arbiter;
    localparam int NB  = 4;
    localparam int IDW = 2;
    localparam int EW  = 8;
    localparam int MW  = 23;
    localparam int EPW = 10;
    localparam int MPW = 28;

`ifdef VFPU_ADD_ARB_RR_EN
    localparam int EXP4 [5] = '{0, 1, 2, 3, 0};
    localparam int EXP13[3] = '{1, 3, 1};
`else
    localparam int EXP4 [5] = '{0, 0, 0, 0, 0};
    localparam int EXP13[3] = '{1, 1, 1};
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NB-1:0] req_valid, req_ready;
    logic [NB-1:0][31:0] opa, opb;
    logic sa, sb, ops_rdy;
    logic [EW-1:0] ea, eb;
    logic [MW:0] ma, mb;
    logic add_done, add_sign;
    logic signed [EPW-1:0] add_exp;
    logic [MPW-1:0] add_mant;
    logic res_valid, res_ready, res_sign;
    logic signed [EPW-1:0] res_exp;
    logic [MPW-1:0] res_mant;
    logic [IDW-1:0] res_id;

    always #5 clk = ~clk;

    vfpu_add_arbiter #(
        .NB_REQ(NB), .ID_W(IDW), .FP_EXP_WIDTH(EW), .FP_MANT_WIDTH(MW),
        .FP_EXP_PRENORM_WIDTH(EPW), .FP_MANT_PRENORM_WIDTH(MPW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_opa_i(opa), .req_opb_i(opb),
        .add_signA_o(sa), .add_signB_o(sb),
        .add_exponentA_o(ea), .add_exponentB_o(eb),
        .add_mantissaA_o(ma), .add_mantissaB_o(mb),
        .add_operandsReady_o(ops_rdy),
        .add_done_i(add_done), .add_sign_i(add_sign),
        .add_exponent_i(add_exp), .add_mantissa_i(add_mant),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sign_o(res_sign), .res_exponent_o(res_exp),
        .res_mantissa_o(res_mant), .res_id_o(res_id)
    );

    // Transaction model: an op is in flight from grant until its result is taken.
    bit m_busy, m_have;
    logic [31:0] m_a, m_b;
    int m_id, m_ptr;
    logic m_rs;
    logic signed [EPW-1:0] m_re;
    logic [MPW-1:0] m_rm;

    bit pend[NB];
    logic [31:0] pa[NB], pb[NB];
    int done_ovr, rdy_ovr;
    bit rearm, gen_en;
    int errors = 0, checks = 0, cycle_no = 0, grants = 0;
    int gq[$], cq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    function automatic int pick(input logic [NB-1:0] v, input int ptr);
        int start;
`ifdef VFPU_ADD_ARB_RR_EN
        start = ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NB; k++)
            if (v[(start + k) % NB]) return (start + k) % NB;
        return -1;
    endfunction

    function automatic int first_set(input logic [NB-1:0] v);
        for (int k = 0; k < NB; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic [7:0] fexp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [23:0] fmant(input logic [31:0] x);
        return {x[30:23] != 8'd0, x[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 3) == 0) x[30:23] = 8'd0;
        return x;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_have = 0; m_a = '0; m_b = '0; m_id = 0; m_ptr = 0;
        m_rs = 1'b0; m_re = '0; m_rm = '0;
    endtask

    task automatic drive();
        logic [7:0] xa, xb;
        for (int i = 0; i < NB; i++) begin
            req_valid[i] = pend[i];
            opa[i] = pa[i];
            opb[i] = pb[i];
        end
        add_done  = (done_ovr >= 0) ? (done_ovr != 0) : ($urandom_range(0, 99) < 60);
        res_ready = (rdy_ovr >= 0) ? (rdy_ovr != 0) : ($urandom_range(0, 99) < 60);
        // Bench adder: sign xor, larger exponent, mantissa sum.
        xa = fexp(m_a);
        xb = fexp(m_b);
        add_sign = m_a[31] ^ m_b[31];
        add_exp  = EPW'((xa > xb) ? xa : xb);
        add_mant = MPW'(fmant(m_a)) + MPW'(fmant(m_b));
        if (!rst_n) model_reset();
    endtask

    task automatic compare_model();
        logic [NB-1:0] er;
        int g;
        er = '0;
        if (!m_busy) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", req_ready, er);
        chk("operands_ready", ops_rdy, m_busy && !m_have);
        chk("res_valid", res_valid, m_have);
        chk("sign_a", sa, m_a[31]);
        chk("sign_b", sb, m_b[31]);
        chk("exp_a", ea, fexp(m_a));
        chk("exp_b", eb, fexp(m_b));
        chk("mant_a", ma, fmant(m_a));
        chk("mant_b", mb, fmant(m_b));
        chk("res_sign", res_sign, m_rs);
        chk("res_exp", res_exp, m_re);
        chk("res_mant", res_mant, m_rm);
        chk("res_id", res_id, m_id);
    endtask

    task automatic settle();
        drive();
        #1;
        compare_model();
    endtask

    task automatic advance();
        int g;
        if (rst_n) begin
            if (!m_busy) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_busy = 1; m_a = opa[g]; m_b = opb[g]; m_id = g;
                    m_ptr = (g + 1) % NB;
                    grants++;
                    if (rearm) begin pa[g] = rand_fp(); pb[g] = rand_fp(); end
                    else pend[g] = 0;
                end
            end else if (!m_have) begin
                if (add_done) begin
                    m_have = 1; m_rs = add_sign; m_re = add_exp; m_rm = add_mant;
                end
            end else if (res_ready) begin
                m_busy = 0; m_have = 0;
            end
        end
        if (gen_en)
            for (int i = 0; i < NB; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; pa[i] = rand_fp(); pb[i] = rand_fp();
                end
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        @(negedge clk);
        cycle_no++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin settle(); tick(); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NB; i++) pend[i] = 0;
        settle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic collect_grants(input int n);
        int g;
        gq.delete();
        cq.delete();
        repeat (n) begin
            settle();
            g = first_set(req_ready);
            if (g >= 0) begin gq.push_back(g); cq.push_back(cycle_no); end
            tick();
        end
    endtask

    initial begin
        int n;
        bit any;
        rst_n = 1'b0;
        req_valid = '0; opa = '0; opb = '0;
        add_done = 0; add_sign = 0; add_exp = '0; add_mant = '0; res_ready = 0;
        for (int i = 0; i < NB; i++) begin pend[i] = 0; pa[i] = '0; pb[i] = '0; end
        done_ovr = 1; rdy_ovr = 1; rearm = 0; gen_en = 0;
        model_reset();

        // Reset values
        settle();
        chk("reset_req_ready", req_ready, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_ops_ready", ops_rdy, 0);
        chk("reset_exp_a", ea, 0);
        chk("reset_res_id", res_id, 0);
        tick();
        rst_n = 1'b1;
        cycles(1);

        // Single request: 1.0 + 2.0 from requester 2, combinational adder
        pend[2] = 1; pa[2] = 32'h3F80_0000; pb[2] = 32'h4000_0000;
        settle(); chk("single_grant", req_ready, 4'b0100); tick();
        settle();
        chk("single_exp_a", ea, 127);
        chk("single_exp_b", eb, 128);
        chk("single_mant_a", ma, 24'h80_0000);
        chk("single_mant_b", mb, 24'h80_0000);
        chk("single_ops_ready", ops_rdy, 1);
        chk("single_res_valid_c1", res_valid, 0);
        tick();
        settle();
        chk("single_res_valid_c2", res_valid, 1);
        chk("single_res_id", res_id, 2);
        chk("single_res_exp", res_exp, 128);
        chk("single_res_sign", res_sign, 0);
        tick();

        // Denormal operand A
        pend[0] = 1; pa[0] = 32'h0000_0001; pb[0] = 32'h0080_0000;
        cycles(1);
        settle();
        chk("denorm_mant_a", ma, 24'h00_0001);
        chk("denorm_exp_a", ea, 0);
        chk("denorm_mant_b", mb, 24'h80_0000);
        chk("denorm_exp_b", eb, 1);
        tick();
        cycles(1);

        // Slow adder (3 idle cycles) then 5 cycles of result backpressure
        done_ovr = 0; rdy_ovr = 0;
        pend[1] = 1; pa[1] = 32'hC040_0000; pb[1] = 32'h3F00_0000;
        settle(); chk("slow_grant", req_ready, 4'b0010); tick();
        repeat (3) begin
            settle();
            chk("slow_ops_ready", ops_rdy, 1);
            chk("slow_res_valid", res_valid, 0);
            chk("slow_sign_a", sa, 1);
            chk("slow_exp_a", ea, 128);
            chk("slow_mant_a", ma, 24'hC0_0000);
            tick();
        end
        done_ovr = 1;
        settle(); chk("slow_res_valid_c4", res_valid, 0); tick();
        done_ovr = 0;
        pend[3] = 1; pa[3] = 32'h4120_0000; pb[3] = 32'h4120_0000;
        repeat (5) begin
            settle();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_res_id", res_id, 1);
            chk("bp_res_sign", res_sign, 1);
            chk("bp_res_exp", res_exp, 128);
            tick();
        end
        rdy_ovr = 1;
        settle();
        chk("bp_release_valid", res_valid, 1);
        chk("bp_release_ready", req_ready, 0);
        tick();
        done_ovr = 1;
        settle();
        chk("bp_idle_grant", req_ready, 4'b1000);
        chk("bp_idle_res_valid", res_valid, 0);
        tick();
        cycles(3);

        // Reset during OPER aborts the operation
        done_ovr = 0;
        pend[0] = 1; pa[0] = 32'h4040_0000; pb[0] = 32'h3F80_0000;
        cycles(1);
        settle(); chk("rst_pre_ops_ready", ops_rdy, 1); tick();
        rst_n = 1'b0;
        settle();
        chk("rst_ops_ready", ops_rdy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_exp_a", ea, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        settle(); chk("rst_after_res_valid", res_valid, 0); tick();

        // All four requesters continuously valid
        done_ovr = 1; rdy_ovr = 1; rearm = 1;
        for (int i = 0; i < NB; i++) begin pend[i] = 1; pa[i] = rand_fp(); pb[i] = rand_fp(); end
        collect_grants(15);
        chk("fair_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("fair_order", gq[i], EXP4[i]);
        for (int i = 1; i < cq.size(); i++) chk("fair_spacing", cq[i] - cq[i-1], 3);
        rearm = 0;
        do_reset();

        // Requesters 1 and 3 continuously valid
        rearm = 1;
        pend[1] = 1; pa[1] = rand_fp(); pb[1] = rand_fp();
        pend[3] = 1; pa[3] = rand_fp(); pb[3] = rand_fp();
        collect_grants(9);
        chk("pair_count", gq.size(), 3);
        for (int i = 0; i < 3 && i < gq.size(); i++) chk("pair_order", gq[i], EXP13[i]);
        rearm = 0;
        do_reset();

        // Random traffic, random adder delay and backpressure
        done_ovr = -1; rdy_ovr = -1; gen_en = 1; grants = 0;
        cycles(3000);
        gen_en = 0;
        n = 0;
        any = 1;
        while (any && n < 2000) begin
            cycles(1);
            n++;
            any = m_busy;
            for (int i = 0; i < NB; i++) if (pend[i]) any = 1;
        end
        chk("drain_done", n < 2000, 1);
        chk("random_progress", grants > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vfpu_add_arbiter.md
# vfpu_add_arbiter

Shares one combinational `vfpu_add` datapath among `NB_REQ` requesters using a valid/ready handshake. Each accepted request carries two IEEE-754 single-precision operands. The block unpacks them into sign, exponent and mantissa with the implied bit, and registers them onto the adder. It then captures the pre-normalisation result and presents it, tagged with the requester index, to the downstream normaliser stage. Only one operation is in flight at a time.

## Interface
- `NB_REQ`, 4: number of requesters, range 2..16.
- `ID_W`, `$clog2(NB_REQ)`: requester tag width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  `NB_REQ`  per-requester request valid.
- `req_ready_o`  out  `NB_REQ`  per-requester accept; at most one bit high.
- `req_opa_i`, `req_opb_i`  in  `NB_REQ`x32  packed float operands A and B.
- `add_signA_o`, `add_signB_o`  out  1  adder operand signs.
- `add_exponentA_o`, `add_exponentB_o`  out  `FP_EXP_WIDTH`  adder operand exponents.
- `add_mantissaA_o`, `add_mantissaB_o`  out  `FP_MANT_WIDTH+1`  mantissas including the implied bit.
- `add_operandsReady_o`  out  1  operands stable on the adder.
- `add_done_i`  in  1  adder result valid.
- `add_sign_i`  in  1  adder result sign.
- `add_exponent_i`  in  `FP_EXP_PRENORM_WIDTH` (signed)  adder result exponent.
- `add_mantissa_i`  in  `FP_MANT_PRENORM_WIDTH`  adder result mantissa.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  downstream accept.
- `res_sign_o`, `res_exponent_o`, `res_mantissa_o`  out  as the `add_*_i` result inputs  registered result.
- `res_id_o`  out  `ID_W`  index of the requester that owns the result.

## Operation
- FSM states: IDLE, OPER, RESP.
- **IDLE**
  - Grant logic is combinational from `req_valid_i`.
  - `req_ready_o[g]` = 1 for the granted index g only.
  - With any valid request, on the edge: register the unpacked operands of g, set `id_q`=g, go to OPER.
  - With no valid request: stay in IDLE.
- **Unpack rule**
  - sign = bit 31, exponent = bits 30:23.
  - mantissa = {exponent != 0, bits 22:0}; denormals get implied bit 0.
  - NaN/Inf are not special-cased; they pass through unchanged.
- **OPER**
  - `add_operandsReady_o` = 1; all `req_ready_o` = 0.
  - When `add_done_i`=1: capture `add_sign_i`, `add_exponent_i`, `add_mantissa_i` into the result registers, go to RESP.
  - When `add_done_i`=0: stay in OPER and hold the operands.
- **RESP**
  - `res_valid_o` = 1; outputs are held stable while `res_ready_i` = 0.
  - On `res_ready_i`=1: go to IDLE.
  - No new grant is made in the same cycle; a new grant can happen in the following IDLE cycle.
- **Grant pointer**
  - `ptr_q` (`ID_W` bits) becomes g+1 on each grant, modulo `NB_REQ`.
  - With round-robin compiled in, the search starts at `ptr_q` and wraps upward.
- **Reset**
  - Asynchronous reset returns the FSM to IDLE from any state, aborting any in-flight operation with no result issued.
  - Values after reset: `ptr_q`=0, `req_ready_o`=0, `add_*_o`=0, `add_operandsReady_o`=0, `res_valid_o`=0, result fields=0, `res_id_o`=0.
  - Exception: `req_ready_o` is combinational, so it may rise in the first IDLE cycle after reset if `req_valid_i` is set.

## Timing
- Handshake: a request transfers in the cycle with `req_valid_i[i]`=1 and `req_ready_o[i]`=1.
- Requesters keep valid and operands stable until accepted.
- `req_ready_o` must not depend on `res_ready_i`.
- Latency with a combinational adder (`add_done_i` = `add_operandsReady_o`): request accepted at cycle 0, `res_valid_o` high at cycle 2.
- Throughput with `res_ready_i` held at 1: one result every 3 cycles (IDLE, OPER, RESP).
- Each extra cycle of `add_done_i`=0 in OPER adds one cycle of latency.
- Simultaneous requests: exactly one is granted; the others see `req_ready_o`=0 and keep waiting.

## Configuration
- `VFPU_ADD_ARB_RR_EN` defined: round-robin arbitration starting at `ptr_q`.
- `VFPU_ADD_ARB_RR_EN` undefined: fixed priority, lowest index wins.
  - `ptr_q` is still updated on each grant but ignored by the grant logic.
  - Starvation of higher indices is permitted in this mode.

## Test plan
- **Single request:** req 2 valid, A=0x3F800000 (1.0), B=0x40000000 (2.0) -> adder sees exponentA=127, exponentB=128, both mantissas 0x800000. `res_valid_o` at cycle 2 with `res_id_o`=2, `res_exponent_o`=128, sign 0.
- **Round-robin fairness** (RR_EN): all four requesters continuously valid, `res_ready_i`=1 -> grant order 0,1,2,3,0, one grant per 3 cycles.
- **Backpressure:** `res_ready_i`=0 for 5 cycles in RESP -> `res_*` held stable, `req_ready_o` stays 0, IDLE entered on the cycle after `res_ready_i`=1.
- **Slow adder:** `add_done_i` held low 3 cycles in OPER -> operands unchanged, `res_valid_o` at cycle 5.
- **Denormal operand:** A=0x00000001 -> `add_mantissaA_o`=0x000001 (implied bit 0), `add_exponentA_o`=0.
- **Reset mid-operation:** `rst_ni` low during OPER -> next cycle IDLE, `res_valid_o`=0, `ptr_q`=0. Fixed-priority build with reqs 1 and 3 valid -> req 1 granted every time.
